// File: rtl/video_dma_pkg.sv
// Shared definitions for the video frame DMA: FSM state encoding,
// control-register bit positions and pixel packing helper.
package video_dma_pkg;

  typedef logic [1:0] dma_state_t;

  localparam dma_state_t S_IDLE  = 2'd0;
  localparam dma_state_t S_READ  = 2'd1;
  localparam dma_state_t S_DRAIN = 2'd2;
  localparam dma_state_t S_DONE  = 2'd3;

  localparam int CTR_START = 0;
  localparam int CTR_CONT  = 1;
  localparam int CTR_ABORT = 2;

  function automatic int pix_per_word(input int pix_w);
    return 32 / pix_w;
  endfunction

endpackage

// File: rtl/video_burst_buf.sv
// One-burst word store between the Wishbone read side and the pixel drain.
// Synchronous write, combinational read; contents are not reset.
module video_burst_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/video_frame_dma.sv
// Frame DMA: reads a frame from memory over a read-only Wishbone master in
// fixed bursts and streams it pixel by pixel, MSB-first, into a FIFO.
//
// state | meaning
// IDLE  | waiting for a start edge
// READ  | Wishbone burst in flight, filling the burst buffer
// DRAIN | writing buffered pixels to the FIFO, stalls on full
// DONE  | end-of-frame interrupt pulse
module video_frame_dma
  import video_dma_pkg::*;
#(
  parameter int P_WIDTH  = 640,
  parameter int P_HEIGHT = 480,
  parameter int PIX_W    = 8,
  parameter int BURST    = 16,
  parameter int INT_LEN  = 4
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [31:0]      wb_reg_data,
  input  logic [31:0]      wb_reg_ctr,
  output logic             interrupt,
  input  logic [31:0]      p_wb_DAT_I,
  input  logic             p_wb_ACK_I,
  output logic             p_wb_STB_O,
  output logic             p_wb_CYC_O,
  output logic             p_wb_LOCK_O,
  output logic             p_wb_WE_O,
  output logic [3:0]       p_wb_SEL_O,
  output logic [31:0]      p_wb_ADR_O,
  input  logic             full,
  output logic             w_e,
  output logic [PIX_W-1:0] pixel_out,
  output logic             busy
);

  localparam int PPW         = pix_per_word(PIX_W);
  localparam int FRAME_WORDS = P_WIDTH * P_HEIGHT / PPW;
  localparam int AW          = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int SW          = (PPW > 1) ? $clog2(PPW) : 1;

  if (!(PIX_W == 8 || PIX_W == 16 || PIX_W == 32)) begin : g_bad_pix_w
    $error("video_frame_dma: PIX_W must be 8, 16 or 32");
  end
  if (FRAME_WORDS % BURST != 0) begin : g_bad_burst
    $error("video_frame_dma: frame word count must be a multiple of BURST");
  end
  if (INT_LEN < 1) begin : g_bad_int_len
    $error("video_frame_dma: INT_LEN must be at least 1");
  end

  dma_state_t    state_q, state_d;
  logic          start_q, armed_q;
  logic [31:0]   base_q, base_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   word_idx_q, word_idx_d;
  logic [31:0]   int_cnt_q, int_cnt_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [AW-1:0] rd_word_q, rd_word_d;
  logic [SW-1:0] sub_q, sub_d;

  logic        start_edge, abort, cont, buf_we;
  logic [31:0] buf_rdata, word_shift;
  logic        unused_ctr;

  // armed_q masks the first cycle after reset so a start bit held through
  // reset is not mistaken for a fresh edge.
  assign start_edge = armed_q & wb_reg_ctr[CTR_START] & ~start_q;
  assign abort      = wb_reg_ctr[CTR_ABORT];
  assign cont       = wb_reg_ctr[CTR_CONT];
  assign buf_we     = (state_q == S_READ) && p_wb_ACK_I;
  assign unused_ctr = ^wb_reg_ctr[31:3];

  video_burst_buf #(
    .DEPTH (BURST),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (wr_idx_q),
    .wdata_i (p_wb_DAT_I),
    .raddr_i (rd_word_q),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    shadow_d   = shadow_q;
    adr_d      = adr_q;
    word_idx_d = word_idx_q;
    int_cnt_d  = int_cnt_q;
    wr_idx_d   = wr_idx_q;
    rd_word_d  = rd_word_q;
    sub_d      = sub_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          base_d     = wb_reg_data;
          shadow_d   = wb_reg_data;
          adr_d      = wb_reg_data;
          word_idx_d = '0;
          wr_idx_d   = '0;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        if (p_wb_ACK_I) begin
          adr_d      = adr_q + 32'd4;
          word_idx_d = word_idx_q + 32'd1;
          wr_idx_d   = wr_idx_q + AW'(1);
          if (wr_idx_q == AW'(BURST - 1)) begin
            wr_idx_d  = '0;
            rd_word_d = '0;
            sub_d     = '0;
            state_d   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!full) begin
          sub_d = sub_q + SW'(1);
          if (sub_q == SW'(PPW - 1)) begin
            sub_d     = '0;
            rd_word_d = rd_word_q + AW'(1);
            if (rd_word_q == AW'(BURST - 1)) begin
              rd_word_d = '0;
              if (word_idx_q == 32'(FRAME_WORDS)) begin
                int_cnt_d = 32'(INT_LEN - 1);
                state_d   = S_DONE;
              end else begin
                wr_idx_d = '0;
                state_d  = S_READ;
              end
            end
          end
        end
      end
      default: begin
        if (int_cnt_q == 32'd0) begin
          if (cont) begin
            base_d     = shadow_q;
            adr_d      = shadow_q;
            word_idx_d = '0;
            wr_idx_d   = '0;
            state_d    = S_READ;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          int_cnt_d = int_cnt_q - 32'd1;
        end
      end
    endcase

    if (state_q != S_IDLE && start_edge && cont) shadow_d = wb_reg_data;

    // Abort overrides everything above, including a same-cycle start.
    if (abort) begin
      state_d   = S_IDLE;
      shadow_d  = shadow_q;
      base_d    = base_q;
      wr_idx_d  = '0;
      rd_word_d = '0;
      sub_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      armed_q    <= 1'b0;
      base_q     <= '0;
      shadow_q   <= '0;
      adr_q      <= '0;
      word_idx_q <= '0;
      int_cnt_q  <= '0;
      wr_idx_q   <= '0;
      rd_word_q  <= '0;
      sub_q      <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= wb_reg_ctr[CTR_START];
      armed_q    <= 1'b1;
      base_q     <= base_d;
      shadow_q   <= shadow_d;
      adr_q      <= adr_d;
      word_idx_q <= word_idx_d;
      int_cnt_q  <= int_cnt_d;
      wr_idx_q   <= wr_idx_d;
      rd_word_q  <= rd_word_d;
      sub_q      <= sub_d;
    end
  end

  assign word_shift = buf_rdata << (sub_q * PIX_W);

  assign p_wb_CYC_O  = (state_q == S_READ);
  assign p_wb_STB_O  = (state_q == S_READ);
  assign p_wb_ADR_O  = adr_q;
  assign p_wb_WE_O   = 1'b0;
  assign p_wb_LOCK_O = 1'b0;
  assign p_wb_SEL_O  = 4'hF;
  assign w_e         = (state_q == S_DRAIN) && !full;
  assign pixel_out   = (state_q == S_DRAIN) ? word_shift[31 -: PIX_W] : '0;
  assign interrupt   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_video_frame_dma.sv
// Bench for video_frame_dma: randomized Wishbone ACK latency and FIFO
// back-pressure checked every cycle against a frame-level expectation model.
module tb_video_frame_dma;

  localparam int PW     = 8;
  localparam int PH     = 2;
  localparam int PIXW   = 8;
  localparam int BST    = 2;
  localparam int ILEN   = 4;
  localparam int PPW    = 32 / PIXW;
  localparam int FWORDS = PW * PH / PPW;
  localparam int FPIX   = PW * PH;

  logic            clk = 1'b0;
  logic            RST = 1'b1;
  logic [31:0]     wb_reg_data = '0;
  logic [31:0]     wb_reg_ctr  = '0;
  logic            interrupt;
  logic [31:0]     p_wb_DAT_I = '0;
  logic            p_wb_ACK_I = 1'b0;
  logic            p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_WE_O;
  logic [3:0]      p_wb_SEL_O;
  logic [31:0]     p_wb_ADR_O;
  logic            full = 1'b0;
  logic            w_e;
  logic [PIXW-1:0] pixel_out;
  logic            busy;

  video_frame_dma #(
    .P_WIDTH (PW), .P_HEIGHT (PH), .PIX_W (PIXW), .BURST (BST), .INT_LEN (ILEN)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .wb_reg_data (wb_reg_data),
    .wb_reg_ctr  (wb_reg_ctr),
    .interrupt   (interrupt),
    .p_wb_DAT_I  (p_wb_DAT_I),
    .p_wb_ACK_I  (p_wb_ACK_I),
    .p_wb_STB_O  (p_wb_STB_O),
    .p_wb_CYC_O  (p_wb_CYC_O),
    .p_wb_LOCK_O (p_wb_LOCK_O),
    .p_wb_WE_O   (p_wb_WE_O),
    .p_wb_SEL_O  (p_wb_SEL_O),
    .p_wb_ADR_O  (p_wb_ADR_O),
    .full        (full),
    .w_e         (w_e),
    .pixel_out   (pixel_out),
    .busy        (busy)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_adr[$];
  logic [7:0]  exp_pix[$];
  logic [31:0] adr_log[$];
  logic [7:0]  pix_log[$];
  int we_total = 0, we_since_irq = 0, irq_run = 0, irq_pulses = 0;
  logic irq_prev = 1'b0;

  int ack_min = 0, ack_max = 0, full_pct = 0;
  logic full_force = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h, nothing was expected at %0t", name, act, $time);
  endtask

  // Memory contents as seen by the DMA: upper half address, lower half its complement.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic push_frame(input logic [31:0] base);
    logic [31:0] a, w;
    for (int i = 0; i < FWORDS; i++) begin
      a = base + 32'(4 * i);
      exp_adr.push_back(a);
      w = memf(a);
      for (int p = 0; p < PPW; p++) exp_pix.push_back(w[31 - 8 * p -: 8]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] data);
    step();
    wb_reg_data = data;
    wb_reg_ctr[0] = 1'b1;
    step();
    wb_reg_ctr[0] = 1'b0;
  endtask

  task automatic kick(input logic [31:0] base);
    push_frame(base);
    pulse_start(base);
  endtask

  task automatic flush_model();
    exp_adr.delete();
    exp_pix.delete();
    we_since_irq = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    if (busy) fail_now("idle_timeout", 32'(n));
    check("adr_left", 32'(exp_adr.size()), 0);
    check("pix_left", 32'(exp_pix.size()), 0);
  endtask

  // Wishbone slave: random wait states per word, data from memf.
  initial begin
    int wait_cnt;
    logic fresh;
    wait_cnt = 0;
    fresh = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!(p_wb_CYC_O && p_wb_STB_O)) begin
        p_wb_ACK_I = 1'b0;
        fresh = 1'b1;
      end else begin
        if (fresh) begin
          wait_cnt = $urandom_range(ack_max, ack_min);
          fresh = 1'b0;
        end
        if (wait_cnt == 0) begin
          p_wb_ACK_I = 1'b1;
          p_wb_DAT_I = memf(p_wb_ADR_O);
          fresh = 1'b1;
        end else begin
          p_wb_ACK_I = 1'b0;
          wait_cnt--;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      full = full_force || (full_pct > 0 && $urandom_range(99, 0) < full_pct);
    end
  end

  // Cycle-by-cycle compare against the expectation queues.
  initial begin
    forever begin
      @(negedge clk);
      if (RST) begin
        irq_run = 0;
        irq_prev = 1'b0;
        continue;
      end
      check("we_tied", p_wb_WE_O, 0);
      check("lock_tied", p_wb_LOCK_O, 0);
      check("sel_tied", p_wb_SEL_O, 4'hF);
      check("stb_eq_cyc", p_wb_STB_O, p_wb_CYC_O);
      if (p_wb_CYC_O) begin
        if (exp_adr.size() == 0) fail_now("adr_unexpected", p_wb_ADR_O);
        else begin
          check("adr", p_wb_ADR_O, exp_adr[0]);
          if (p_wb_ACK_I) begin
            adr_log.push_back(p_wb_ADR_O);
            void'(exp_adr.pop_front());
          end
        end
      end
      if (full) check("we_while_full", w_e, 0);
      if (w_e) begin
        if (exp_pix.size() == 0) fail_now("pix_unexpected", 32'(pixel_out));
        else check("pixel", 32'(pixel_out), 32'(exp_pix.pop_front()));
        pix_log.push_back(pixel_out);
        we_total++;
        we_since_irq++;
      end
      if (interrupt) begin
        if (!irq_prev) begin
          check("pixels_before_irq", 32'(we_since_irq), FPIX);
          we_since_irq = 0;
        end
        irq_run++;
      end else if (irq_prev) begin
        check("irq_len", 32'(irq_run), ILEN);
        irq_pulses++;
        irq_run = 0;
      end
      irq_prev = interrupt;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, we0, gap, n;
    logic [31:0] rb;

    // Reset values, with start held high through reset.
    wb_reg_ctr = 32'h1;
    #12;
    check("rst_cyc", p_wb_CYC_O, 0);
    check("rst_stb", p_wb_STB_O, 0);
    check("rst_we", w_e, 0);
    check("rst_irq", interrupt, 0);
    check("rst_busy", busy, 0);
    check("rst_adr", p_wb_ADR_O, 0);
    check("rst_pix", 32'(pixel_out), 0);
    step();
    RST = 1'b0;
    repeat (6) step();
    check("no_start_after_rst", busy, 0);
    wb_reg_ctr = 32'h0;
    step();

    // Basic frame, zero wait states, no back-pressure.
    adr_log.delete();
    pix_log.delete();
    p0 = irq_pulses;
    kick(32'h1000);
    wait_idle(500);
    check("adr0", adr_log.size() > 0 ? adr_log[0] : 32'hDEAD, 32'h1000);
    check("adr1", adr_log.size() > 1 ? adr_log[1] : 32'hDEAD, 32'h1004);
    check("adr2", adr_log.size() > 2 ? adr_log[2] : 32'hDEAD, 32'h1008);
    check("adr3", adr_log.size() > 3 ? adr_log[3] : 32'hDEAD, 32'h100C);
    check("pix_count", 32'(pix_log.size()), 16);
    if (pix_log.size() == 16) begin
      check("pix0", 32'(pix_log[0]), 32'h10);
      check("pix3", 32'(pix_log[3]), 32'hFF);
      check("pix5", 32'(pix_log[5]), 32'h04);
      check("pix7", 32'(pix_log[7]), 32'hFB);
    end
    check("irq_pulses_basic", 32'(irq_pulses - p0), 1);

    // FIFO full for 5 cycles mid-drain.
    pix_log.delete();
    we0 = we_total;
    kick(32'h1000);
    n = 0;
    while (we_total - we0 < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("drain_timeout", 32'(n));
    full_force = 1'b1;
    n = 0;
    while (!full && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      check("full_stall", w_e, 0);
      @(negedge clk);
    end
    full_force = 1'b0;
    wait_idle(500);
    check("pix_count_full", 32'(pix_log.size()), 16);

    // Three wait states per word.
    ack_min = 3;
    ack_max = 3;
    kick(32'h0000_4440);
    wait_idle(1000);

    // Random latency, random back-pressure, random bases, plus a 32-bit address wrap.
    ack_min = 0;
    ack_max = 3;
    full_pct = 30;
    for (int k = 0; k < 6; k++) begin
      rb = (k == 5) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      kick(rb);
      wait_idle(2000);
    end
    full_pct = 0;
    ack_max = 0;

    // Abort on the first ACK.
    we0 = we_total;
    p0 = irq_pulses;
    kick(32'h0000_8000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p_wb_CYC_O && p_wb_ACK_I) && n < 50);
    if (n >= 50) fail_now("ack_timeout", 32'(n));
    wb_reg_ctr[2] = 1'b1;
    step();
    check("abort_cyc", p_wb_CYC_O, 0);
    check("abort_busy", busy, 0);
    flush_model();
    repeat (20) step();
    check("abort_no_we", 32'(we_total - we0), 0);
    check("abort_no_irq", 32'(irq_pulses - p0), 0);
    wb_reg_ctr = 32'h0;
    step();

    // Abort wins over a simultaneous start.
    wb_reg_ctr = 32'h5;
    step();
    check("abort_beats_start", busy, 0);
    wb_reg_ctr = 32'h0;
    step();
    check("abort_beats_start2", busy, 0);

    // Continuous mode: new base via start-while-busy, then repeat at that base.
    wb_reg_ctr = 32'h2;
    p0 = irq_pulses;
    kick(32'h3000);
    repeat (2) step();
    push_frame(32'h2000);
    pulse_start(32'h2000);
    gap = 0;
    n = 0;
    while (irq_pulses < p0 + 1 && n < 500) begin
      @(negedge clk);
      n++;
      if (!busy) gap++;
    end
    push_frame(32'h2000);
    while (irq_pulses < p0 + 2 && n < 1000) begin
      @(negedge clk);
      n++;
      if (!busy) gap++;
    end
    if (n >= 1000) fail_now("cont_timeout", 32'(n));
    check("cont_gap", 32'(gap), 0);
    wb_reg_ctr[1] = 1'b0;
    wait_idle(500);
    check("cont_frames", 32'(irq_pulses - p0), 3);

    // Reset mid-READ drops the bus asynchronously.
    ack_min = 3;
    ack_max = 3;
    kick(32'h0000_6000);
    n = 0;
    while (!p_wb_CYC_O && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2;
    RST = 1'b1;
    #1;
    check("arst_cyc", p_wb_CYC_O, 0);
    check("arst_stb", p_wb_STB_O, 0);
    check("arst_we", w_e, 0);
    check("arst_irq", interrupt, 0);
    check("arst_busy", busy, 0);
    check("arst_adr", p_wb_ADR_O, 0);
    check("arst_pix", 32'(pixel_out), 0);
    flush_model();
    step();
    RST = 1'b0;
    ack_min = 0;
    ack_max = 1;
    repeat (3) step();
    kick(32'h0000_0500);
    wait_idle(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
